ram_burst_ctrl: RTL and testbench

//  Burst request front-end that drives the 64x8 single-port RAM. Accepts one

---
 rtl/ram_burst_ctrl.sv | 97 +++++++++
 tb/tb_ram_burst_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_ctrl.sv
// Burst front-end for a 64x8 single-port RAM: accepts read/write bursts, streams beats.
// Define RAM_BURST_CTRL_BURST_EN to honour req_len; otherwise every request is a single beat.
module ram_burst_ctrl #(
    parameter int AW = 6,
    parameter int DW = 8,
    parameter int LW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wr,
    input  logic [AW-1:0] req_addr,
    input  logic [LW-1:0] req_len,
    input  logic          wdata_valid,
    output logic          wdata_ready,
    input  logic [DW-1:0] wdata,
    output logic          rdata_valid,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    // Handshakes: a request transfers on a rising edge with req_valid && req_ready,
    // a write beat with wdata_valid && wdata_ready; rdata_valid has no backpressure.
    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] cur_addr, addr_nxt;
    logic [LW-1:0] cnt, cnt_nxt;
    logic [LW-1:0] len_eff;

`ifdef RAM_BURST_CTRL_BURST_EN
    assign len_eff = req_len;
`else
    assign len_eff = req_len & {LW{1'b0}};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cur_addr    <= '0;
            cnt         <= '0;
            rdata_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            cur_addr    <= addr_nxt;
            cnt         <= cnt_nxt;
            // Each READ cycle issues one beat; its data comes back one cycle later.
            rdata_valid <= (state == READ);
        end
    end

    always_comb begin
        state_nxt   = state;
        addr_nxt    = cur_addr;
        cnt_nxt     = cnt;
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        ram_we      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_nxt  = req_addr;
                    cnt_nxt   = len_eff;
                    state_nxt = req_wr ? WRITE : READ;
                end
            end
            WRITE: begin
                wdata_ready = 1'b1;
                ram_we      = wdata_valid;
                if (wdata_valid) begin
                    addr_nxt = cur_addr + 1'b1;
                    cnt_nxt  = cnt - 1'b1;
                    if (cnt == '0) state_nxt = IDLE;
                end
            end
            READ: begin
                addr_nxt = cur_addr + 1'b1;
                cnt_nxt  = cnt - 1'b1;
                if (cnt == '0) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign ram_addr = cur_addr;
    assign ram_din  = wdata;
    assign rdata    = ram_dout;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl: behavioural RAM, reference memory image, table + random bursts.
module tb_ram_burst_ctrl;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int LW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0, req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_len = '0;
    logic          wdata_valid = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          req_ready, wdata_ready, rdata_valid, busy, ram_we;
    logic [DW-1:0] rdata, ram_din, ram_dout;
    logic [AW-1:0] ram_addr;

    logic [DW-1:0] mem [64];
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int we_count = 0;

    always #5 clk = ~clk;

    ram_burst_ctrl #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata(rdata), .busy(busy),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Registered-output single-port RAM.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
        if (rst && ram_we) we_count++;
    end

    function automatic int eff_beats(input int len);
`ifdef RAM_BURST_CTRL_BURST_EN
        return len + 1;
`else
        return 1;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        for (int k = 0; k < 200 && !req_ready; k++) tick();
        chk("idle_wait", req_ready, 1'b1);
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [5:0] len, input logic [7:0] base,
                            input int gap_at, input int gap_len, input int nb);
        int we0;
        logic [5:0] a;
        wait_idle();
        req_valid = 1'b1; req_wr = 1'b1; req_addr = addr; req_len = len;
        tick();
        req_valid = 1'b0;
        we0 = we_count;
        for (int i = 0; i < nb; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    wdata_valid = 1'b0;
                    req_valid = 1'b1; req_wr = 1'b0; req_addr = 6'($urandom);
                    @(negedge clk);
                    chk("gap_we", ram_we, 1'b0);
                    chk("gap_req_ready", req_ready, 1'b0);
                    tick();
                end
                req_valid = 1'b0;
            end
            a = addr + 6'(i);
            wdata_valid = 1'b1;
            wdata = base + 8'(i * 8'h11);
            @(negedge clk);
            chk("wr_we", ram_we, 1'b1);
            chk("wr_addr", ram_addr, a);
            chk("wr_ready", wdata_ready, 1'b1);
            ref_mem[a] = wdata;
            tick();
        end
        wdata_valid = 1'b0;
        @(negedge clk);
        chk("wr_busy_end", busy, 1'b0);
        chk("wr_we_count", we_count - we0, nb);
        tick();
    endtask

    task automatic do_read(input logic [5:0] addr, input logic [5:0] len, input int nb);
        logic [7:0] e;
        wait_idle();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = addr; req_len = len;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < nb; i++) exp_q.push_back(ref_mem[6'(addr + 6'(i))]);
        @(negedge clk);
        chk("rd_first_cycle_valid", rdata_valid, 1'b0);
        tick();
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            chk("rd_valid", rdata_valid, 1'b1);
            e = exp_q.pop_front();
            chk("rd_data", rdata, e);
            if (i == nb - 1) chk("rd_drain_ready", req_ready, 1'b0);
            tick();
        end
        @(negedge clk);
        chk("rd_end_valid", rdata_valid, 1'b0);
        chk("rd_end_busy", busy, 1'b0);
        tick();
    endtask

    typedef struct {
        bit         wr;
        logic [5:0] addr;
        logic [5:0] len;
        logic [7:0] base;
        int         gap_at;
        int         gap_len;
        int         exp_beats;
    } vec_t;

    vec_t vecs[9];

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 8'(i * 3 + 1);
            ref_mem[i] = 8'(i * 3 + 1);
        end
        vecs[0] = '{1'b1, 6'h3E, 6'd3,  8'hAA, -1, 0, eff_beats(3)};
        vecs[1] = '{1'b0, 6'h3E, 6'd3,  8'h00, -1, 0, eff_beats(3)};
        vecs[2] = '{1'b1, 6'h05, 6'd4,  8'h10,  2, 3, eff_beats(4)};
        vecs[3] = '{1'b0, 6'h05, 6'd4,  8'h00, -1, 0, eff_beats(4)};
        vecs[4] = '{1'b1, 6'h20, 6'd63, 8'h01, 10, 1, eff_beats(63)};
        vecs[5] = '{1'b0, 6'h00, 6'd0,  8'h00, -1, 0, eff_beats(0)};
        vecs[6] = '{1'b0, 6'h21, 6'd63, 8'h00, -1, 0, eff_beats(63)};
        vecs[7] = '{1'b1, 6'h3F, 6'd0,  8'hE0, -1, 0, eff_beats(0)};
        vecs[8] = '{1'b1, 6'h30, 6'd5,  8'h40, -1, 0, eff_beats(5)};

        // Power-on reset
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_wdata_ready", wdata_ready, 1'b0);
        chk("rst_we", ram_we, 1'b0);
        chk("rst_rvalid", rdata_valid, 1'b0);
        chk("rst_addr", ram_addr, 6'h00);
        tick();
        rst = 1'b1;
        tick();

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].wr)
                do_write(vecs[v].addr, vecs[v].len, vecs[v].base, vecs[v].gap_at,
                         vecs[v].gap_len, vecs[v].exp_beats);
            else
                do_read(vecs[v].addr, vecs[v].len, vecs[v].exp_beats);
            if (v == 0) chk("mem_3e_after_write", mem[6'h3E], 8'hAA);
        end

        // Reset in the middle of a write burst: no write after the reset.
        do_write(6'h10, 6'd0, 8'h5A, -1, 0, 1);
        wait_idle();
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 6'h12; req_len = 6'd7;
        tick();
        req_valid = 1'b0;
        wdata_valid = 1'b1; wdata = 8'h66;
        @(negedge clk);
        ref_mem[6'h12] = 8'h66;
        tick();
        wdata = 8'h77;
        #2 rst = 1'b0;
        #1;
        chk("rstw_busy", busy, 1'b0);
        chk("rstw_we", ram_we, 1'b0);
        chk("rstw_req_ready", req_ready, 1'b1);
        chk("rstw_rvalid", rdata_valid, 1'b0);
        wdata_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        do_read(6'h10, 6'd3, eff_beats(3));

        // Reset during an 8-beat read.
        wait_idle();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 6'h00; req_len = 6'd7;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        chk("rstr_rvalid", rdata_valid, 1'b0);
        chk("rstr_busy", busy, 1'b0);
        tick();
        rst = 1'b1;
        tick();

        // Random bursts against the reference memory image.
        for (int n = 0; n < 40; n++) begin
            logic [5:0] a, l;
            int nb;
            a = 6'($urandom);
            l = 6'($urandom_range(0, 20));
            nb = eff_beats(int'(l));
            if ($urandom_range(0, 1) == 1)
                do_write(a, l, 8'($urandom), $urandom_range(0, nb), $urandom_range(0, 3), nb);
            else
                do_read(a, l, nb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
